// File: rtl/mux_eight_arbiter_if.sv
// mux_eight_arbiter_if
// Bundles the request/data inputs and the grant/select/result outputs of the
// eight-way shared-line arbiter.
//   req    [7:0] : request vector, bit i = requester i
//   d      [7:0] : data bits, d[i] belongs to requester i
//   gnt    [7:0] : one-hot grant, zero when idle
//   sel    [2:0] : index of the current/last owner
//   busy         : high while a grant is active
//   result       : d[sel] while busy, else 0
// master = requester side, slave = arbiter side.
interface mux_eight_arbiter_if;
  logic [7:0] req;
  logic [7:0] d;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       result;

  modport master (output req, output d, input gnt, input sel, input busy, input result);
  modport slave  (input req, input d, output gnt, output sel, output busy, output result);
endinterface

// File: rtl/mux_eight_arbiter.sv
// mux_eight_arbiter
// Round-robin arbiter and sequencer for an 8-to-1 single-bit selector.
// One requester owns the shared line at a time. Ownership ends when the owner
// drops its request or after MAX_HOLD consecutive cycles. Priority then rotates
// to the index just above the released owner.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mux_eight_arbiter_if.slave (req, d in; gnt, sel, busy, result out)
// Parameter:
//   MAX_HOLD : maximum consecutive grant cycles, 1..16
module mux_eight_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  mux_eight_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [0:0] state_r, state_nx_s;
  logic [2:0] ptr_r, ptr_nx_s;
  logic [3:0] hcnt_r, hcnt_nx_s;
  logic [2:0] sel_r, sel_nx_s;
  logic [7:0] gnt_r, gnt_nx_s;
  logic       busy_r, busy_nx_s;

  logic       release_s;
  logic       any_req_s;
  logic [2:0] start_s;
  logic [2:0] winner_s;

  // First set bit of r scanning upward from start, modulo 8. Scanning offsets
  // from high to low lets the smallest offset overwrite the others.
  function automatic logic [2:0] find_winner(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] win;
    win = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) begin
        win = idx;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  // A release happens when the owner lets go or its hold budget is spent.
  assign release_s = (state_r == GRANT) && (!bus.req[sel_r] || (hcnt_r == HOLD_LAST));
  assign any_req_s = |bus.req;
  // On release the search starts just above the owner, which makes a
  // hold-limited owner the lowest priority for the re-grant. When the owner
  // dropped, its req bit is already 0, so no explicit mask is needed.
  assign start_s   = release_s ? (sel_r + 3'd1) : ptr_r;
  assign winner_s  = find_winner(bus.req, start_s);

  // Next-state and next-output computation.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    hcnt_nx_s  = hcnt_r;
    sel_nx_s   = sel_r;
    gnt_nx_s   = gnt_r;
    busy_nx_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nx_s = GRANT;
          sel_nx_s   = winner_s;
          gnt_nx_s   = 8'd1 << winner_s;
          busy_nx_s  = 1'b1;
          hcnt_nx_s  = 4'd0;
        end else begin
          gnt_nx_s  = 8'd0;
          busy_nx_s = 1'b0;
        end
      end
      GRANT: begin
        if (!release_s) begin
          hcnt_nx_s = hcnt_r + 4'd1;
        end else begin
          ptr_nx_s = start_s;
          if (any_req_s) begin
            sel_nx_s  = winner_s;
            gnt_nx_s  = 8'd1 << winner_s;
            busy_nx_s = 1'b1;
            hcnt_nx_s = 4'd0;
          end else begin
            // sel keeps the last owner so the selector stays stable.
            state_nx_s = IDLE;
            gnt_nx_s   = 8'd0;
            busy_nx_s  = 1'b0;
            hcnt_nx_s  = 4'd0;
          end
        end
      end
      default: begin
        state_nx_s = IDLE;
        gnt_nx_s   = 8'd0;
        busy_nx_s  = 1'b0;
        hcnt_nx_s  = 4'd0;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      hcnt_r  <= 4'd0;
      sel_r   <= 3'd0;
      gnt_r   <= 8'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
      hcnt_r  <= hcnt_nx_s;
      sel_r   <= sel_nx_s;
      gnt_r   <= gnt_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.sel    = sel_r;
  assign bus.busy   = busy_r;
  // Unregistered selector path: follows d combinationally.
  assign bus.result = busy_r ? bus.d[sel_r] : 1'b0;

endmodule

// File: tb/tb_mux_eight_arbiter.sv
// tb_mux_eight_arbiter
// Drives three arbiters (MAX_HOLD = 4, 2, 1) with the same req/d stream.
// A behavioural ownership model predicts every output on every cycle, and
// hand-computed literals pin the expected behaviour in the directed scenarios.
module tb_mux_eight_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_v;
  logic [7:0] d_v;

  always #5 clk = ~clk;

  mux_eight_arbiter_if ia ();
  mux_eight_arbiter_if ib ();
  mux_eight_arbiter_if ic ();

  assign ia.req = req_v;
  assign ia.d   = d_v;
  assign ib.req = req_v;
  assign ib.d   = d_v;
  assign ic.req = req_v;
  assign ic.d   = d_v;

  mux_eight_arbiter #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mux_eight_arbiter #(.MAX_HOLD(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  mux_eight_arbiter #(.MAX_HOLD(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  logic [7:0] gnt_a [3];
  logic [2:0] sel_a [3];
  logic       busy_a[3];
  logic       res_a [3];

  assign gnt_a[0] = ia.gnt;  assign sel_a[0] = ia.sel;  assign busy_a[0] = ia.busy;  assign res_a[0] = ia.result;
  assign gnt_a[1] = ib.gnt;  assign sel_a[1] = ib.sel;  assign busy_a[1] = ib.busy;  assign res_a[1] = ib.result;
  assign gnt_a[2] = ic.gnt;  assign sel_a[2] = ic.sel;  assign busy_a[2] = ic.busy;  assign res_a[2] = ic.result;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Ownership model: owner (-1 when idle), last owner, cycles held so far,
  // and the index where the next search starts.
  int mh   [3] = '{4, 2, 1};
  int owner[3] = '{-1, -1, -1};
  int last [3] = '{0, 0, 0};
  int held [3] = '{0, 0, 0};
  int nxt  [3] = '{0, 0, 0};

  initial begin
    logic [7:0] eg;
    logic       er;
    int         c;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          owner[k] = -1; last[k] = 0; held[k] = 0; nxt[k] = 0;
        end else begin
          if (owner[k] >= 0) begin
            if (req_v[owner[k]] && held[k] < mh[k]) begin
              held[k]++;
            end else begin
              nxt[k]   = (owner[k] + 1) % 8;
              owner[k] = -1;
            end
          end
          if (owner[k] < 0) begin
            for (int off = 0; off < 8; off++) begin
              c = (nxt[k] + off) % 8;
              if (owner[k] < 0 && req_v[c]) begin
                owner[k] = c; last[k] = c; held[k] = 1;
              end
            end
          end
        end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        eg = 8'h00;
        er = 1'b0;
        if (owner[k] >= 0) begin
          eg[owner[k]] = 1'b1;
          er = d_v[last[k]];
        end
        chk($sformatf("model_gnt[%0d]", k),    gnt_a[k],        eg);
        chk($sformatf("model_sel[%0d]", k),    8'(sel_a[k]),    8'(last[k]));
        chk($sformatf("model_busy[%0d]", k),   8'(busy_a[k]),   8'(owner[k] >= 0));
        chk($sformatf("model_result[%0d]", k), 8'(res_a[k]),    8'(er));
      end
    end
  end

  // Apply inputs at a falling edge and return at the next falling edge, so
  // the rising edge in between has sampled them.
  task automatic cyc(input logic [7:0] r, input logic [7:0] dd);
    req_v = r;
    d_v   = dd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(8'h00, 8'h00);
    rst = 1'b0;
  endtask

  logic [7:0] vec_r [16] = '{8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h81, 8'h81, 8'h81, 8'h81,
                             8'h81, 8'h3C, 8'h18, 8'hFF, 8'h01, 8'h80, 8'h80, 8'h00};
  logic [7:0] vec_d [16] = '{8'hFF, 8'h0F, 8'hF0, 8'hFF, 8'h80, 8'h01, 8'h81, 8'h00,
                             8'h80, 8'h24, 8'h10, 8'h55, 8'h01, 8'h80, 8'h00, 8'hFF};

  initial begin
    rst   = 1'b1;
    req_v = 8'h00;
    d_v   = 8'h00;
    cyc(8'h00, 8'h00);
    cyc(8'h00, 8'h00);
    chk("reset_gnt",    gnt_a[0],        8'h00);
    chk("reset_sel",    8'(sel_a[0]),    8'h00);
    chk("reset_busy",   8'(busy_a[0]),   8'h00);
    chk("reset_result", 8'(res_a[0]),    8'h00);
    rst = 1'b0;

    // Reset mid-grant
    cyc(8'h10, 8'h00);
    chk("rmg_gnt0", gnt_a[0], 8'h10);
    cyc(8'h10, 8'h00);
    rst = 1'b1;
    cyc(8'h10, 8'h00);
    chk("rmg_gnt_rst", gnt_a[0],     8'h00);
    chk("rmg_sel_rst", 8'(sel_a[0]), 8'h00);
    rst = 1'b0;
    cyc(8'h10, 8'h00);
    chk("rmg_gnt_after", gnt_a[0],     8'h10);
    chk("rmg_sel_after", 8'(sel_a[0]), 8'h04);
    cyc(8'h00, 8'h00);

    // Single requester held past the hold limit; d[3] toggles
    for (int i = 0; i < 6; i++) begin
      cyc(8'h08, (i % 2 == 0) ? 8'h08 : 8'hF7);
      chk("single_gnt",    gnt_a[0],     8'h08);
      chk("single_sel",    8'(sel_a[0]), 8'h03);
      chk("single_result", 8'(res_a[0]), (i % 2 == 0) ? 8'h01 : 8'h00);
    end
    cyc(8'h00, 8'h00);

    // Round-robin fairness with everybody requesting
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(8'hFF, 8'h00);
      chk("rr_sel_h2",  8'(sel_a[1]),  8'((i / 2) % 8));
      chk("rr_busy_h2", 8'(busy_a[1]), 8'h01);
      chk("rr_sel_h1",  8'(sel_a[2]),  8'(i % 8));
    end
    cyc(8'h00, 8'h00);

    // Early drop and wrap-around
    do_reset();
    cyc(8'h40, 8'h00);
    chk("wrap_first", 8'(sel_a[0]), 8'h06);
    cyc(8'h82, 8'h00);
    chk("wrap_to7",   8'(sel_a[0]), 8'h07);
    chk("wrap_gnt7",  gnt_a[0],     8'h80);
    cyc(8'h02, 8'h00);
    chk("wrap_to1",   8'(sel_a[0]), 8'h01);
    cyc(8'h00, 8'h00);

    // Idle return, then wrap of the pointer from 3 back to 0
    do_reset();
    cyc(8'h04, 8'h00);
    cyc(8'h04, 8'h00);
    chk("idle_sel_busy", 8'(sel_a[0]), 8'h02);
    cyc(8'h00, 8'hFF);
    chk("idle_busy",   8'(busy_a[0]), 8'h00);
    chk("idle_gnt",    gnt_a[0],      8'h00);
    chk("idle_result", 8'(res_a[0]),  8'h00);
    chk("idle_sel",    8'(sel_a[0]),  8'h02);
    cyc(8'h01, 8'h00);
    chk("idle_regrant_sel", 8'(sel_a[0]), 8'h00);
    chk("idle_regrant_gnt", gnt_a[0],     8'h01);
    cyc(8'h00, 8'h00);

    // Data path: result follows d[5] combinationally within the cycle
    do_reset();
    cyc(8'h20, 8'h20);
    chk("dp_result_1", 8'(res_a[0]), 8'h01);
    d_v = 8'h00;
    #1;
    chk("dp_result_0", 8'(res_a[0]), 8'h00);
    d_v = 8'h20;
    #1;
    chk("dp_result_back", 8'(res_a[0]), 8'h01);
    cyc(8'h00, 8'hFF);
    chk("dp_idle_result", 8'(res_a[0]), 8'h00);

    // Mixed directed vectors, checked by the model only
    for (int i = 0; i < 16; i++) begin
      cyc(vec_r[i], vec_d[i]);
    end
    cyc(8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
